ex_unit: RTL and testbench

EX_UNIT -- requirements
Module: ex_unit

---
 rtl/ex_unit_pkg.sv | 42 ++++
 rtl/ex_unit_shifter.sv | 86 ++++++++
 rtl/ex_unit.sv | 163 ++++++++++++++++
 tb/tb_ex_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_unit_pkg.sv
// Shared codes for the execute stage: zones, ALU opcodes, compare funct3 and exception causes.
package ex_unit_pkg;

  typedef enum logic [1:0] {
    ZONE_NONE    = 2'd0,
    ZONE_REGFILE = 2'd1,
    ZONE_LOADQ   = 2'd2,
    ZONE_STOREQ  = 2'd3
  } zone_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_PASSR = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    F3_EQ  = 3'b000,
    F3_NE  = 3'b001,
    F3_LT  = 3'b100,
    F3_GE  = 3'b101,
    F3_LTU = 3'b110,
    F3_GEU = 3'b111
  } cmp_f3_e;

  localparam logic [3:0] EXC_JUMP_MISALIGN = 4'd0;

  typedef enum logic {SH_IDLE, SH_SHIFT} sh_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/ex_unit_shifter.sv
// Iterative shifter: moves up to C_SHIFT_STEP bit positions per enabled cycle.
module ex_shifter
  import ex_unit_pkg::*;
#(
  parameter int C_XLEN       = 32,
  parameter int C_SHIFT_STEP = 4
) (
  input  logic                       clk_i,
  input  logic                       resetb_i,
  input  logic                       en_i,
  input  logic                       start_i,
  input  logic [3:0]                 op_i,
  input  logic [$clog2(C_XLEN)-1:0]  amount_i,
  input  logic [C_XLEN-1:0]          data_i,
  output logic                       busy_o,
  output logic [C_XLEN-1:0]          result_o
);
  localparam int SHW = $clog2(C_XLEN);
  // One extra bit so a step equal to C_XLEN is still representable.
  localparam logic [SHW:0] STEP = (SHW+1)'(C_SHIFT_STEP);

  sh_state_e          state_q, state_d;
  logic [SHW-1:0]     rem_q, rem_d;
  logic [C_XLEN-1:0]  data_q, data_d;
  logic [3:0]         op_q, op_d;
  logic [SHW:0]       step_amt;
  logic [C_XLEN-1:0]  shifted;

  assign step_amt = ({1'b0, rem_q} > STEP) ? STEP : {1'b0, rem_q};

  // One partial shift of the held operand.
  always_comb begin
    case (op_q)
      ALU_SLL: shifted = data_q << step_amt;
      ALU_SRA: shifted = $signed(data_q) >>> step_amt;
      default: shifted = data_q >> step_amt;
    endcase
  end

  // Next-state: load on start, step until nothing remains.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    op_d    = op_q;
    case (state_q)
      SH_IDLE: begin
        if (start_i) begin
          data_d = data_i;
          op_d   = op_i;
          rem_d  = amount_i;
          if (amount_i != '0) state_d = SH_SHIFT;
        end
      end
      SH_SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - step_amt[SHW-1:0];
        if (rem_d == '0) state_d = SH_IDLE;
      end
      default: state_d = SH_IDLE;
    endcase
  end

  // Control state; frozen while the global enable is low.
  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      state_q <= SH_IDLE;
      rem_q   <= '0;
    end else if (en_i) begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Datapath holding registers, no reset needed.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= data_d;
      op_q   <= op_d;
    end
  end

  assign busy_o   = (state_q == SH_SHIFT);
  assign result_o = data_q;

endmodule

// File: rtl/ex_unit.sv
// Execute stage: one-slot ALU/compare/branch unit with iterative shifter and LSQ dispatch.
module ex_unit
  import ex_unit_pkg::*;
#(
  parameter int C_XLEN       = 32,
  parameter int C_COMPRESSED = 0,
  parameter int C_SHIFT_STEP = 4
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              ids_valid_i,
  output logic              ids_stall_o,
  input  logic              ids_jump_i,
  input  logic              ids_cond_i,
  input  logic              ids_link_i,
  input  logic              ids_ins_size_i,
  input  logic [1:0]        ids_zone_i,
  input  logic [3:0]        ids_alu_op_i,
  input  logic [2:0]        ids_funct3_i,
  input  logic [C_XLEN-1:0] ids_pc_i,
  input  logic [C_XLEN-1:0] ids_operand_left_i,
  input  logic [C_XLEN-1:0] ids_operand_right_i,
  input  logic [C_XLEN-1:0] ids_regs1_data_i,
  input  logic [C_XLEN-1:0] ids_regs2_data_i,
  input  logic [4:0]        ids_regd_addr_i,
  output logic              ids_regd_wr_o,
  output logic [4:0]        ids_regd_addr_o,
  output logic [C_XLEN-1:0] ids_regd_data_o,
  output logic              hvec_jump_o,
  output logic [C_XLEN-1:0] hvec_jump_addr_o,
  output logic              hvec_exc_o,
  output logic [3:0]        hvec_exc_cause_o,
  input  logic              lsq_lq_full_i,
  input  logic              lsq_sq_full_i,
  output logic              lsq_lq_wr_o,
  output logic              lsq_sq_wr_o,
  output logic [2:0]        lsq_funct3_o,
  output logic [4:0]        lsq_regd_addr_o,
  output logic [C_XLEN-1:0] lsq_regs2_data_o,
  output logic [C_XLEN-1:0] lsq_addr_o
);
  localparam int SHW = $clog2(C_XLEN);

  logic              valid_q, jump_q, cond_q, link_q, size_q, cmp_q, shf_q;
  logic [1:0]        zone_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [C_XLEN-1:0] pc_q, res_q, rs2_q;
  logic [C_XLEN-1:0] res_d;
  logic              cmp_d;
  logic [SHW-1:0]    shamt;
  logic              cap, sh_start, sh_busy;
  logic [C_XLEN-1:0] sh_res, result, target;
  logic              ready, commit, take, exc;

  assign shamt = ids_operand_right_i[SHW-1:0];

  // Single-cycle ALU; shift ops yield the unshifted operand, correct for amount 0.
  always_comb begin
    res_d = '0;
    case (ids_alu_op_i)
      ALU_ADD:   res_d = ids_operand_left_i + ids_operand_right_i;
      ALU_SUB:   res_d = ids_operand_left_i - ids_operand_right_i;
      ALU_AND:   res_d = ids_operand_left_i & ids_operand_right_i;
      ALU_OR:    res_d = ids_operand_left_i | ids_operand_right_i;
      ALU_XOR:   res_d = ids_operand_left_i ^ ids_operand_right_i;
      ALU_SLT:   res_d = {{(C_XLEN-1){1'b0}},
                          ($signed(ids_operand_left_i) < $signed(ids_operand_right_i))};
      ALU_SLTU:  res_d = {{(C_XLEN-1){1'b0}}, (ids_operand_left_i < ids_operand_right_i)};
      ALU_PASSR: res_d = ids_operand_right_i;
      ALU_SLL, ALU_SRL, ALU_SRA: res_d = ids_operand_left_i;
      default:   res_d = '0;
    endcase
  end

  // Branch condition on the register operands.
  always_comb begin
    cmp_d = 1'b0;
    case (ids_funct3_i)
      F3_EQ:   cmp_d = (ids_regs1_data_i == ids_regs2_data_i);
      F3_NE:   cmp_d = (ids_regs1_data_i != ids_regs2_data_i);
      F3_LT:   cmp_d = ($signed(ids_regs1_data_i) <  $signed(ids_regs2_data_i));
      F3_GE:   cmp_d = ($signed(ids_regs1_data_i) >= $signed(ids_regs2_data_i));
      F3_LTU:  cmp_d = (ids_regs1_data_i <  ids_regs2_data_i);
      F3_GEU:  cmp_d = (ids_regs1_data_i >= ids_regs2_data_i);
      default: cmp_d = 1'b0;
    endcase
  end

  assign cap      = clk_en_i & ~ids_stall_o;
  assign sh_start = cap & ids_valid_i & is_shift(ids_alu_op_i) & (shamt != '0);

  // Slot occupancy; a capture with no valid input empties the slot.
  always_ff @(posedge clk_i) begin
    if (!resetb_i) valid_q <= 1'b0;
    else if (cap)  valid_q <= ids_valid_i;
  end

  // Captured instruction fields and the precomputed non-shift result.
  always_ff @(posedge clk_i) begin
    if (cap) begin
      jump_q   <= ids_jump_i;
      cond_q   <= ids_cond_i;
      link_q   <= ids_link_i;
      size_q   <= (C_COMPRESSED != 0) ? ids_ins_size_i : 1'b1;
      zone_q   <= ids_zone_i;
      funct3_q <= ids_funct3_i;
      rd_q     <= ids_regd_addr_i;
      pc_q     <= ids_pc_i;
      rs2_q    <= ids_regs2_data_i;
      res_q    <= res_d;
      cmp_q    <= cmp_d;
      shf_q    <= is_shift(ids_alu_op_i) & (shamt != '0);
    end
  end

  ex_shifter #(
    .C_XLEN       (C_XLEN),
    .C_SHIFT_STEP (C_SHIFT_STEP)
  ) u_shifter (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .en_i     (clk_en_i),
    .start_i  (sh_start),
    .op_i     (ids_alu_op_i),
    .amount_i (shamt),
    .data_i   (ids_operand_left_i),
    .busy_o   (sh_busy),
    .result_o (sh_res)
  );

  assign ready = ~sh_busy
               & ~((zone_q == ZONE_LOADQ)  & lsq_lq_full_i)
               & ~((zone_q == ZONE_STOREQ) & lsq_sq_full_i);

  assign ids_stall_o = valid_q & ~ready;

  // Nothing retires while reset is asserted, so strobes are quiet that cycle.
  assign commit = clk_en_i & resetb_i & valid_q & ready;
  assign take   = commit & (~cond_q | cmp_q);

  assign result = shf_q ? sh_res : res_q;
  assign target = {result[C_XLEN-1:1], 1'b0};
  assign exc    = take & jump_q & (C_COMPRESSED == 0) & target[1];

  assign ids_regd_wr_o    = take & (zone_q == ZONE_REGFILE) & (rd_q != 5'd0) & ~exc;
  assign ids_regd_addr_o  = rd_q;
  assign ids_regd_data_o  = link_q ? (pc_q + (size_q ? C_XLEN'(4) : C_XLEN'(2))) : result;

  assign hvec_jump_o      = take & jump_q & ~exc;
  assign hvec_jump_addr_o = target;
  assign hvec_exc_o       = exc;
  assign hvec_exc_cause_o = EXC_JUMP_MISALIGN;

  assign lsq_lq_wr_o      = take & (zone_q == ZONE_LOADQ);
  assign lsq_sq_wr_o      = take & (zone_q == ZONE_STOREQ);
  assign lsq_funct3_o     = funct3_q;
  assign lsq_regd_addr_o  = rd_q;
  assign lsq_regs2_data_o = rs2_q;
  assign lsq_addr_o       = result;

endmodule

// File: tb/tb_ex_unit.sv
// Self-checking bench: table vectors, corner sequences and random traffic on two configurations.
module tb_ex_unit;
  import ex_unit_pkg::*;

  localparam int XL = 32;
  localparam int STEP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb_i, clk_en_i, ids_valid_i, ids_jump_i, ids_cond_i, ids_link_i, ids_ins_size_i;
  logic [1:0] ids_zone_i;
  logic [3:0] ids_alu_op_i;
  logic [2:0] ids_funct3_i;
  logic [XL-1:0] ids_pc_i, ids_operand_left_i, ids_operand_right_i, ids_regs1_data_i, ids_regs2_data_i;
  logic [4:0] ids_regd_addr_i;
  logic lsq_lq_full_i, lsq_sq_full_i;

  logic a_stall, a_wr, a_jmp, a_exc, a_lq, a_sq, c_stall, c_wr, c_jmp, c_exc, c_lq, c_sq;
  logic [4:0] a_rd, a_lrd, c_rd, c_lrd;
  logic [XL-1:0] a_data, a_jaddr, a_rs2, a_laddr, c_data, c_jaddr, c_rs2, c_laddr;
  logic [3:0] a_cause, c_cause;
  logic [2:0] a_f3, c_f3;

  ex_unit #(.C_XLEN(XL), .C_COMPRESSED(0), .C_SHIFT_STEP(STEP)) u_dut (
    .clk_i(clk), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .ids_valid_i(ids_valid_i), .ids_stall_o(a_stall),
    .ids_jump_i(ids_jump_i), .ids_cond_i(ids_cond_i), .ids_link_i(ids_link_i),
    .ids_ins_size_i(ids_ins_size_i), .ids_zone_i(ids_zone_i), .ids_alu_op_i(ids_alu_op_i),
    .ids_funct3_i(ids_funct3_i), .ids_pc_i(ids_pc_i), .ids_operand_left_i(ids_operand_left_i),
    .ids_operand_right_i(ids_operand_right_i), .ids_regs1_data_i(ids_regs1_data_i),
    .ids_regs2_data_i(ids_regs2_data_i), .ids_regd_addr_i(ids_regd_addr_i),
    .ids_regd_wr_o(a_wr), .ids_regd_addr_o(a_rd), .ids_regd_data_o(a_data),
    .hvec_jump_o(a_jmp), .hvec_jump_addr_o(a_jaddr), .hvec_exc_o(a_exc), .hvec_exc_cause_o(a_cause),
    .lsq_lq_full_i(lsq_lq_full_i), .lsq_sq_full_i(lsq_sq_full_i),
    .lsq_lq_wr_o(a_lq), .lsq_sq_wr_o(a_sq), .lsq_funct3_o(a_f3), .lsq_regd_addr_o(a_lrd),
    .lsq_regs2_data_o(a_rs2), .lsq_addr_o(a_laddr));

  ex_unit #(.C_XLEN(XL), .C_COMPRESSED(1), .C_SHIFT_STEP(STEP)) u_dutc (
    .clk_i(clk), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .ids_valid_i(ids_valid_i), .ids_stall_o(c_stall),
    .ids_jump_i(ids_jump_i), .ids_cond_i(ids_cond_i), .ids_link_i(ids_link_i),
    .ids_ins_size_i(ids_ins_size_i), .ids_zone_i(ids_zone_i), .ids_alu_op_i(ids_alu_op_i),
    .ids_funct3_i(ids_funct3_i), .ids_pc_i(ids_pc_i), .ids_operand_left_i(ids_operand_left_i),
    .ids_operand_right_i(ids_operand_right_i), .ids_regs1_data_i(ids_regs1_data_i),
    .ids_regs2_data_i(ids_regs2_data_i), .ids_regd_addr_i(ids_regd_addr_i),
    .ids_regd_wr_o(c_wr), .ids_regd_addr_o(c_rd), .ids_regd_data_o(c_data),
    .hvec_jump_o(c_jmp), .hvec_jump_addr_o(c_jaddr), .hvec_exc_o(c_exc), .hvec_exc_cause_o(c_cause),
    .lsq_lq_full_i(lsq_lq_full_i), .lsq_sq_full_i(lsq_sq_full_i),
    .lsq_lq_wr_o(c_lq), .lsq_sq_wr_o(c_sq), .lsq_funct3_o(c_f3), .lsq_regd_addr_o(c_lrd),
    .lsq_regs2_data_o(c_rs2), .lsq_addr_o(c_laddr));

  typedef struct {
    logic [3:0] op; logic [XL-1:0] l, r, r1, r2, pc; logic [2:0] f3;
    logic [1:0] zone; logic [4:0] rd; logic cond, jump, link, size;
  } ins_t;

  typedef struct {
    logic wr; logic [4:0] rd; logic [XL-1:0] data; logic jump; logic [XL-1:0] jaddr;
    logic exc; logic [3:0] cause; logic lq, sq; logic [XL-1:0] laddr; int lat;
  } obs_t;

  typedef struct { ins_t ins; logic [4:0] strb; logic [XL-1:0] data, jaddr; int lat; } vec_t;

  int checks = 0;
  int fails = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic [3:0] op, input logic [XL-1:0] l, input logic [XL-1:0] r,
                              input logic [1:0] zone, input logic [4:0] rd);
    ins_t i;
    i.op = op; i.l = l; i.r = r; i.zone = zone; i.rd = rd;
    i.r1 = '0; i.r2 = '0; i.pc = 32'h100; i.f3 = 3'b000;
    i.cond = 1'b0; i.jump = 1'b0; i.link = 1'b0; i.size = 1'b1;
    return i;
  endfunction

  task automatic add(input ins_t i, input logic [4:0] strb, input logic [XL-1:0] data,
                     input logic [XL-1:0] jaddr, input int lat);
    vec_t v;
    v.ins = i; v.strb = strb; v.data = data; v.jaddr = jaddr; v.lat = lat;
    tbl.push_back(v);
  endtask

  // Reference behaviour at retirement, straight from the instruction semantics.
  function automatic obs_t model(input ins_t i, input bit comp);
    obs_t e;
    logic [XL-1:0] res, tgt;
    logic signed [XL-1:0] sl;
    int amt;
    bit take, cmp, sz, shift;
    amt = int'(i.r % XL);
    sl = i.l;
    shift = (i.op == ALU_SLL) || (i.op == ALU_SRL) || (i.op == ALU_SRA);
    case (i.op)
      ALU_ADD:   res = i.l + i.r;
      ALU_SUB:   res = i.l - i.r;
      ALU_AND:   res = i.l & i.r;
      ALU_OR:    res = i.l | i.r;
      ALU_XOR:   res = i.l ^ i.r;
      ALU_SLT:   res = ($signed(i.l) < $signed(i.r)) ? 1 : 0;
      ALU_SLTU:  res = (i.l < i.r) ? 1 : 0;
      ALU_PASSR: res = i.r;
      ALU_SLL:   res = i.l << amt;
      ALU_SRL:   res = i.l >> amt;
      ALU_SRA:   res = sl >>> amt;
      default:   res = '0;
    endcase
    case (i.f3)
      3'b000: cmp = (i.r1 == i.r2);
      3'b001: cmp = (i.r1 != i.r2);
      3'b100: cmp = ($signed(i.r1) < $signed(i.r2));
      3'b101: cmp = ($signed(i.r1) >= $signed(i.r2));
      3'b110: cmp = (i.r1 < i.r2);
      3'b111: cmp = (i.r1 >= i.r2);
      default: cmp = 0;
    endcase
    take = !i.cond || cmp;
    sz = comp ? i.size : 1'b1;
    tgt = res & ~32'h1;
    e.exc = take && i.jump && !comp && tgt[1];
    e.wr = take && (i.zone == 2'd1) && (i.rd != 0) && !e.exc;
    e.rd = i.rd;
    e.data = i.link ? i.pc + (sz ? 4 : 2) : res;
    e.jump = take && i.jump && !e.exc;
    e.jaddr = tgt;
    e.cause = 4'd0;
    e.lq = take && (i.zone == 2'd2);
    e.sq = take && (i.zone == 2'd3);
    e.laddr = res;
    e.lat = (shift && amt != 0) ? 1 + (amt + STEP - 1) / STEP : 1;
    return e;
  endfunction

  function automatic obs_t samp(input bit c);
    obs_t o;
    o.wr = c ? c_wr : a_wr;       o.rd = c ? c_rd : a_rd;
    o.data = c ? c_data : a_data; o.jump = c ? c_jmp : a_jmp;
    o.jaddr = c ? c_jaddr : a_jaddr; o.exc = c ? c_exc : a_exc;
    o.cause = c ? c_cause : a_cause; o.lq = c ? c_lq : a_lq;
    o.sq = c ? c_sq : a_sq;       o.laddr = c ? c_laddr : a_laddr;
    o.lat = 0;
    return o;
  endfunction

  task automatic drive(input ins_t i);
    ids_alu_op_i = i.op; ids_operand_left_i = i.l; ids_operand_right_i = i.r;
    ids_regs1_data_i = i.r1; ids_regs2_data_i = i.r2; ids_pc_i = i.pc;
    ids_funct3_i = i.f3; ids_zone_i = i.zone; ids_regd_addr_i = i.rd;
    ids_cond_i = i.cond; ids_jump_i = i.jump; ids_link_i = i.link; ids_ins_size_i = i.size;
  endtask

  function automatic logic [9:0] strobes();
    return {a_wr, a_jmp, a_exc, a_lq, a_sq, c_wr, c_jmp, c_exc, c_lq, c_sq};
  endfunction

  // Issue one instruction into an empty stage and record what each DUT retires.
  task automatic issue(input ins_t i, output obs_t oa, output obs_t oc);
    bit da, dc;
    int lat;
    oa = samp(0); oc = samp(1); oa.lat = -1; oc.lat = -1; da = 0; dc = 0;
    @(negedge clk); drive(i); ids_valid_i = 1'b1;
    @(negedge clk); ids_valid_i = 1'b0; lat = 1;
    while (!(da && dc) && lat < 40) begin
      if (!da && !a_stall) begin oa = samp(0); oa.lat = lat; da = 1; end
      if (!dc && !c_stall) begin oc = samp(1); oc.lat = lat; dc = 1; end
      @(negedge clk); lat++;
    end
    chk("single_strobe", 64'(strobes()), 64'd0);
  endtask

  task automatic cmp_obs(input string nm, input obs_t o, input obs_t e);
    chk({nm, ".lat"}, 64'(o.lat), 64'(e.lat));
    chk({nm, ".strb"}, 64'({o.wr, o.jump, o.exc, o.lq, o.sq}), 64'({e.wr, e.jump, e.exc, e.lq, e.sq}));
    if (e.wr) begin
      chk({nm, ".data"}, 64'(o.data), 64'(e.data));
      chk({nm, ".rd"}, 64'(o.rd), 64'(e.rd));
    end
    if (e.jump) chk({nm, ".jaddr"}, 64'(o.jaddr), 64'(e.jaddr));
    if (e.exc) chk({nm, ".cause"}, 64'(o.cause), 64'(e.cause));
    if (e.lq || e.sq) chk({nm, ".laddr"}, 64'(o.laddr), 64'(e.laddr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t i;
    obs_t oa, oc;
    int nz;

    // Vectors for the COMPRESSED=0 instance; strb = {wr, jump, exc, lq, sq}.
    add(mk(ALU_ADD, 7, 32'hFFFF_FFFD, 2'd1, 5), 5'b10000, 32'h4, 0, 1);
    add(mk(ALU_SLL, 1, 13, 2'd1, 3), 5'b10000, 32'h2000, 0, 5);
    i = mk(ALU_ADD, 32'h100, 8, 2'd0, 0); i.cond = 1; i.jump = 1; i.r1 = 5; i.r2 = 6;
    add(i, 5'b00000, 0, 0, 1);
    i.f3 = 3'b001; i.r = 32'h20;
    add(i, 5'b01000, 0, 32'h120, 1);
    i = mk(ALU_PASSR, 0, 32'h102, 2'd1, 1); i.jump = 1; i.link = 1; i.size = 0;
    add(i, 5'b00100, 0, 0, 1);
    i.r = 32'h204;
    add(i, 5'b11000, 32'h104, 32'h204, 1);
    add(mk(ALU_SLT, 32'h8000_0000, 1, 2'd1, 9), 5'b10000, 1, 0, 1);
    add(mk(ALU_SLTU, 1, 32'hFFFF_FFFF, 2'd1, 9), 5'b10000, 1, 0, 1);
    add(mk(ALU_SLT, 1, 32'hFFFF_FFFF, 2'd1, 9), 5'b10000, 0, 0, 1);
    add(mk(ALU_SUB, 0, 1, 2'd1, 10), 5'b10000, 32'hFFFF_FFFF, 0, 1);
    add(mk(ALU_SRA, 32'h8000_0000, 31, 2'd1, 11), 5'b10000, 32'hFFFF_FFFF, 0, 9);
    add(mk(ALU_SRL, 32'h8000_0000, 4, 2'd1, 12), 5'b10000, 32'h0800_0000, 0, 2);
    add(mk(ALU_ADD, 1, 2, 2'd1, 0), 5'b00000, 0, 0, 1);
    i = mk(ALU_ADD, 1, 2, 2'd1, 7); i.cond = 1; i.f3 = 3'b111; i.r1 = 1; i.r2 = 32'hFFFF_FFFF;
    add(i, 5'b00000, 0, 0, 1);
    i.f3 = 3'b010; i.r2 = 1;
    add(i, 5'b00000, 0, 0, 1);
    i = mk(ALU_PASSR, 0, 32'h301, 2'd0, 0); i.jump = 1;
    add(i, 5'b01000, 0, 32'h300, 1);
    add(mk(ALU_ADD, 32'h1000, 8, 2'd2, 4), 5'b00010, 32'h1008, 0, 1);
    add(mk(ALU_ADD, 32'h2000, 32'h10, 2'd3, 4), 5'b00001, 32'h2010, 0, 1);
    add(mk(ALU_SLL, 32'hABCD, 32'h20, 2'd1, 2), 5'b10000, 32'hABCD, 0, 1);
    add(mk(ALU_XOR, 32'hF0F0, 32'hFF00, 2'd1, 13), 5'b10000, 32'h0FF0, 0, 1);
    add(mk(ALU_OR, 32'hF0F0, 32'h0F0F, 2'd1, 14), 5'b10000, 32'hFFFF, 0, 1);
    add(mk(ALU_AND, 32'hF0F0, 32'hFF00, 2'd1, 15), 5'b10000, 32'hF000, 0, 1);

    // Reset holds the stage empty even with valid input presented.
    drive(mk(ALU_ADD, 1, 1, 2'd1, 1));
    resetb_i = 0; clk_en_i = 1; ids_valid_i = 1; lsq_lq_full_i = 0; lsq_sq_full_i = 0;
    repeat (3) @(negedge clk);
    chk("reset.stall", 64'({a_stall, c_stall}), 64'd0);
    chk("reset.strobes", 64'(strobes()), 64'd0);
    resetb_i = 1; ids_valid_i = 0;
    @(negedge clk);
    chk("post_reset.stall", 64'({a_stall, c_stall}), 64'd0);

    foreach (tbl[k]) begin
      issue(tbl[k].ins, oa, oc);
      chk($sformatf("tbl%0d.lat", k), 64'(oa.lat), 64'(tbl[k].lat));
      chk($sformatf("tbl%0d.strb", k), 64'({oa.wr, oa.jump, oa.exc, oa.lq, oa.sq}), 64'(tbl[k].strb));
      if (tbl[k].strb[4]) chk($sformatf("tbl%0d.data", k), 64'(oa.data), 64'(tbl[k].data));
      if (tbl[k].strb[4]) chk($sformatf("tbl%0d.rd", k), 64'(oa.rd), 64'(tbl[k].ins.rd));
      if (tbl[k].strb[3]) chk($sformatf("tbl%0d.jaddr", k), 64'(oa.jaddr), 64'(tbl[k].jaddr));
      if (tbl[k].strb[2]) chk($sformatf("tbl%0d.cause", k), 64'(oa.cause), 64'd0);
      if (tbl[k].strb[1] || tbl[k].strb[0])
        chk($sformatf("tbl%0d.laddr", k), 64'(oa.laddr), 64'(tbl[k].data));
      cmp_obs($sformatf("tblc%0d", k), oc, model(tbl[k].ins, 1));
    end

    // Store held off by a full store queue, then dispatched exactly once.
    lsq_sq_full_i = 1;
    @(negedge clk); i = mk(ALU_ADD, 32'h2000, 32'h10, 2'd3, 9); i.r2 = 32'hDEAD; i.f3 = 3'b010;
    drive(i); ids_valid_i = 1;
    @(negedge clk); ids_valid_i = 0;
    repeat (3) begin
      chk("sq_full.hold", 64'({a_stall, a_sq, c_stall, c_sq}), 64'b1010);
      @(negedge clk);
    end
    lsq_sq_full_i = 0; #1;
    chk("sq_full.release", 64'({a_sq, a_stall, c_sq}), 64'b101);
    chk("sq_full.fields", {a_laddr, a_rs2}, {32'h2010, 32'hDEAD});
    chk("sq_full.f3rd", 64'({a_f3, a_lrd}), 64'({3'b010, 5'd9}));
    @(negedge clk);
    chk("sq_full.once", 64'({a_sq, c_sq}), 64'd0);

    // Shifting proceeds while the load queue is full.
    lsq_lq_full_i = 1;
    @(negedge clk); drive(mk(ALU_SLL, 1, 8, 2'd2, 3)); ids_valid_i = 1;
    @(negedge clk); ids_valid_i = 0;
    repeat (2) begin
      chk("lq_shift.hold", 64'({a_stall, a_lq}), 64'b10);
      @(negedge clk);
    end
    lsq_lq_full_i = 0; #1;
    chk("lq_shift.release", 64'({a_lq, a_stall, c_lq}), 64'b101);
    chk("lq_shift.addr", 64'(a_laddr), 64'h100);
    @(negedge clk);

    // Clock enable low freezes the slot and masks strobes.
    @(negedge clk); drive(mk(ALU_ADD, 10, 20, 2'd1, 6)); ids_valid_i = 1;
    @(negedge clk); ids_valid_i = 0; clk_en_i = 0; #1;
    chk("clk_en.mask", 64'(strobes()), 64'd0);
    @(negedge clk);
    chk("clk_en.frozen", 64'(strobes()), 64'd0);
    clk_en_i = 1; #1;
    chk("clk_en.commit", 64'({a_wr, a_data}), 64'({1'b1, 32'd30}));
    @(negedge clk);
    chk("clk_en.once", 64'(strobes()), 64'd0);

    // Reset in the middle of an arithmetic right shift aborts it.
    @(negedge clk); drive(mk(ALU_SRA, 32'h8000_0000, 31, 2'd1, 8)); ids_valid_i = 1;
    @(negedge clk); ids_valid_i = 0;
    @(negedge clk);
    chk("rst_shift.busy", 64'({a_stall, c_stall}), 64'b11);
    resetb_i = 0; #1;
    chk("rst_shift.strobes", 64'(strobes()), 64'd0);
    @(negedge clk);
    chk("rst_shift.stall", 64'({a_stall, c_stall}), 64'd0);
    resetb_i = 1; nz = 0;
    repeat (12) begin
      @(negedge clk);
      if (strobes() != 0) nz++;
    end
    chk("rst_shift.nocommit", 64'(nz), 64'd0);

    // Random traffic against the reference model on both configurations.
    for (int n = 0; n < 80; n++) begin
      i.op = 4'($urandom_range(0, 10));
      i.l = $urandom; i.r = $urandom; i.r1 = $urandom;
      i.r2 = ($urandom_range(0, 3) == 0) ? i.r1 : $urandom;
      i.pc = $urandom & 32'hFFFF_FFFC; i.f3 = 3'($urandom);
      i.zone = 2'($urandom); i.rd = 5'($urandom);
      i.cond = 1'($urandom); i.jump = ($urandom_range(0, 3) == 0);
      i.link = 1'($urandom); i.size = 1'($urandom);
      issue(i, oa, oc);
      cmp_obs($sformatf("rnd%0d.a", n), oa, model(i, 0));
      cmp_obs($sformatf("rnd%0d.c", n), oc, model(i, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
